// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : core_pkg
//  Description: Shared types and constants for the accumulator core.
//  Revision   : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int DATA_W  = 8;
    localparam int CMD_MSB = 7;
    localparam int CMD_LSB = 6;
    localparam int VAL_MSB = 5;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_LDI = 2'b00;
    localparam cmd_t CMD_ADD = 2'b01;
    localparam cmd_t CMD_AND = 2'b10;
    localparam cmd_t CMD_OR  = 2'b11;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_LOAD = 2'b01,
        FS_RUN  = 2'b10,
        FS_DONE = 2'b11
    } fetch_state_t;

    function automatic cmd_t instr_cmd(input logic [DATA_W-1:0] instr);
        return instr[CMD_MSB:CMD_LSB];
    endfunction

    function automatic logic [VAL_MSB:0] instr_value(input logic [DATA_W-1:0] instr);
        return instr[VAL_MSB:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/program_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface  : program_fetch_unit_if
//  Description: Loader stream, instruction stream and status of the fetch unit.
//  Revision   : 1.0 - initial release
// ============================================================================
interface program_fetch_unit_if
    import core_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W   = 4
);
    logic                load_valid;
    logic [DATA_W_P-1:0] load_data;
    logic                load_last;
    logic                load_ready;
    logic                start;
    logic                instr_valid;
    logic [DATA_W_P-1:0] instruction;
    logic                instr_ready;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W:0]     prog_len;
    logic                busy;
    logic                halted;
    logic                load_error;

    // master = the fetch unit, slave = loader / decoder side
    modport master (
        input  load_valid, load_data, load_last, start, instr_ready,
        output load_ready, instr_valid, instruction, pc, prog_len,
               busy, halted, load_error
    );

    modport slave (
        output load_valid, load_data, load_last, start, instr_ready,
        input  load_ready, instr_valid, instruction, pc, prog_len,
               busy, halted, load_error
    );

endinterface
`default_nettype wire

// File: rtl/program_fetch_unit_prog_ram.sv
`default_nettype none
// ============================================================================
//  Module     : prog_ram
//  Description: Program store, synchronous write, asynchronous read, no reset.
//  Revision   : 1.0 - initial release
// ============================================================================
module prog_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/program_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module     : program_fetch_unit
//  Description: Loads a program into RAM from a byte stream, then streams it out.
//  Revision   : 1.0 - initial release
// ============================================================================
module program_fetch_unit
    import core_pkg::*;
#(
    parameter int MEM_DEPTH = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    program_fetch_unit_if.master bus
);

    localparam logic [1:0] S_IDLE = FS_IDLE;
    localparam logic [1:0] S_LOAD = FS_LOAD;
    localparam logic [1:0] S_RUN  = FS_RUN;
    localparam logic [1:0] S_DONE = FS_DONE;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W + 1)'(MEM_DEPTH);

    logic [1:0]        state_q,       state_d;
    logic [ADDR_W-1:0] wr_ptr_q,      wr_ptr_d;
    logic [ADDR_W-1:0] pc_q,          pc_d;
    logic [ADDR_W:0]   prog_len_q,    prog_len_d;
    logic [DATA_W-1:0] instruction_q, instruction_d;
    logic              instr_valid_q, instr_valid_d;
    logic              load_error_q,  load_error_d;

    logic              load_ready;
    logic              beat;
    logic              handshake;
    logic              at_last;
    logic [ADDR_W-1:0] ram_waddr;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    assign load_ready = (state_q != S_RUN);
    assign beat       = bus.load_valid && load_ready;
    assign handshake  = (state_q == S_RUN) && instr_valid_q && bus.instr_ready;
    assign at_last    = ({1'b0, pc_q} == (prog_len_q - 1'b1));

    // A beat outside LOAD always starts a fresh program at address 0; outside RUN
    // the read port points at address 0 so RUN entry can register mem[0].
    assign ram_waddr = (state_q == S_LOAD) ? wr_ptr_q : '0;
    assign ram_raddr = (state_q == S_RUN) ? (pc_q + 1'b1) : '0;

    prog_ram #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_prog_ram (
        .clock (clock),
        .we    (beat),
        .waddr (ram_waddr),
        .wdata (bus.load_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        pc_d          = pc_q;
        prog_len_d    = prog_len_q;
        instruction_d = instruction_q;
        instr_valid_d = instr_valid_q;
        load_error_d  = load_error_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (beat) begin
                    load_error_d = 1'b0;
                    if (bus.load_last) begin
                        prog_len_d = (ADDR_W + 1)'(1);
                        state_d    = S_IDLE;
                    end else begin
                        prog_len_d = '0;
                        wr_ptr_d   = ADDR_W'(1);
                        state_d    = S_LOAD;
                    end
                end else if (bus.start && (prog_len_q != '0)) begin
                    pc_d          = '0;
                    instruction_d = ram_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = S_RUN;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    if (bus.load_last) begin
                        prog_len_d = {1'b0, wr_ptr_q} + 1'b1;
                        state_d    = S_IDLE;
                    end else if (wr_ptr_q == LAST_ADDR) begin
                        // Store full: keep what fits and flag the truncation.
                        prog_len_d   = FULL_LEN;
                        load_error_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (handshake) begin
                    if (at_last) begin
                        instr_valid_d = 1'b0;
                        state_d       = S_DONE;
                    end else begin
                        pc_d          = pc_q + 1'b1;
                        instruction_d = ram_rdata;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            pc_q          <= '0;
            prog_len_q    <= '0;
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
            load_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            pc_q          <= pc_d;
            prog_len_q    <= prog_len_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            load_error_q  <= load_error_d;
        end
    end

    assign bus.load_ready  = load_ready;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instruction = instruction_q;
    assign bus.pc          = pc_q;
    assign bus.prog_len    = prog_len_q;
    assign bus.busy        = (state_q == S_LOAD) || (state_q == S_RUN);
    assign bus.halted      = (state_q == S_DONE);
    assign bus.load_error  = load_error_q;

endmodule
`default_nettype wire

// File: tb/tb_program_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module     : tb_program_fetch_unit
//  Description: Directed bench for program_fetch_unit (16-deep and 4-deep stores).
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_program_fetch_unit;

    logic clock;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    program_fetch_unit_if #(.ADDR_W(4)) bus  ();
    program_fetch_unit_if #(.ADDR_W(2)) bus4 ();

    program_fetch_unit #(.MEM_DEPTH(16), .ADDR_W(4)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    program_fetch_unit #(.MEM_DEPTH(4), .ADDR_W(2)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.load_valid = 1'b0;  bus.load_last = 1'b0;  bus.start = 1'b0;  bus.instr_ready = 1'b0;
        bus4.load_valid = 1'b0; bus4.load_last = 1'b0; bus4.start = 1'b0; bus4.instr_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic beat16(input logic [7:0] d, input logic last);
        bus.load_valid = 1'b1; bus.load_data = d; bus.load_last = last;
        tick();
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
    endtask

    task automatic beat4(input logic [7:0] d, input logic last);
        bus4.load_valid = 1'b1; bus4.load_data = d; bus4.load_last = last;
        tick();
        bus4.load_valid = 1'b0; bus4.load_last = 1'b0;
    endtask

    task automatic start16();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic load_prog3();
        beat16(8'h03, 1'b0);
        beat16(8'h47, 1'b0);
        beat16(8'h84, 1'b1);
    endtask

    task automatic test_reset();
        logic [20:0] got;
        logic [14:0] got4;
        do_reset();
        got = {bus.instr_valid, bus.instruction, bus.pc, bus.prog_len,
               bus.load_error, bus.halted, bus.busy, bus.load_ready};
        n_cmp++;
        if (got !== {1'b0, 8'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset16: got %h want %h", got, {1'b0, 8'h00, 4'h0, 5'h00, 4'b0001});
        end
        got4 = {bus4.instr_valid, bus4.instruction, bus4.prog_len, bus4.load_error, bus4.load_ready};
        n_cmp++;
        if (got4 !== {1'b0, 8'h00, 3'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset4: got %h want %h", got4, {1'b0, 8'h00, 3'h0, 2'b01});
        end
    endtask

    task automatic test_load_run();
        logic [7:0] exp_i [3] = '{8'h03, 8'h47, 8'h84};
        do_reset();
        load_prog3();
        n_cmp++;
        if ({bus.prog_len, bus.load_error, bus.busy} !== {5'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL load3: prog_len/err/busy got %h/%b/%b want 3/0/0",
                     bus.prog_len, bus.load_error, bus.busy);
        end
        bus.instr_ready = 1'b1;
        start16();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({bus.instr_valid, bus.pc, bus.instruction} !== {1'b1, 4'(k), exp_i[k]}) begin
                n_fail++;
                $display("FAIL run_step%0d: valid/pc/instr got %b/%h/%h want 1/%h/%h",
                         k, bus.instr_valid, bus.pc, bus.instruction, 4'(k), exp_i[k]);
            end
            tick();
        end
        n_cmp++;
        if ({bus.instr_valid, bus.halted, bus.busy, bus.pc} !== {1'b0, 1'b1, 1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL run_halt: valid/halted/busy/pc got %b/%b/%b/%h want 0/1/0/2",
                     bus.instr_valid, bus.halted, bus.busy, bus.pc);
        end
    endtask

    task automatic test_stall();
        bus.instr_ready = 1'b0;
        start16();
        n_cmp++;
        if ({bus.instr_valid, bus.pc, bus.instruction, bus.halted} !== {1'b1, 4'd0, 8'h03, 1'b0}) begin
            n_fail++;
            $display("FAIL restart: valid/pc/instr/halted got %b/%h/%h/%b want 1/0/03/0",
                     bus.instr_valid, bus.pc, bus.instruction, bus.halted);
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({bus.instr_valid, bus.pc, bus.instruction} !== {1'b1, 4'd1, 8'h47}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: valid/pc/instr got %b/%h/%h want 1/1/47",
                         k, bus.instr_valid, bus.pc, bus.instruction);
            end
            if (k < 2) tick();
        end
        bus.instr_ready = 1'b1;
        tick();
        n_cmp++;
        if ({bus.instr_valid, bus.pc, bus.instruction} !== {1'b1, 4'd2, 8'h84}) begin
            n_fail++;
            $display("FAIL stall_release: valid/pc/instr got %b/%h/%h want 1/2/84",
                     bus.instr_valid, bus.pc, bus.instruction);
        end
        tick();
        n_cmp++;
        if ({bus.instr_valid, bus.halted} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_halt: valid/halted got %b/%b want 0/1", bus.instr_valid, bus.halted);
        end
    endtask

    task automatic test_load_in_run();
        logic [7:0] exp_i [3] = '{8'h03, 8'h47, 8'h84};
        bus.instr_ready = 1'b0;
        start16();
        bus.load_valid = 1'b1; bus.load_data = 8'hFF; bus.load_last = 1'b1;
        #1;
        n_cmp++;
        if (bus.load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL run_load_ready: got %b want 0", bus.load_ready);
        end
        repeat (2) tick();
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        n_cmp++;
        if ({bus.prog_len, bus.busy, bus.instr_valid, bus.instruction} !== {5'd3, 1'b1, 1'b1, 8'h03}) begin
            n_fail++;
            $display("FAIL run_load_ignored: len/busy/valid/instr got %h/%b/%b/%h want 3/1/1/03",
                     bus.prog_len, bus.busy, bus.instr_valid, bus.instruction);
        end
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({bus.instr_valid, bus.pc, bus.instruction} !== {1'b1, 4'(k), exp_i[k]}) begin
                n_fail++;
                $display("FAIL ram_kept%0d: valid/pc/instr got %b/%h/%h want 1/%h/%h",
                         k, bus.instr_valid, bus.pc, bus.instruction, 4'(k), exp_i[k]);
            end
            tick();
        end
        n_cmp++;
        if ({bus.halted, bus.prog_len} !== {1'b1, 5'd3}) begin
            n_fail++;
            $display("FAIL ram_kept_halt: halted/len got %b/%h want 1/3", bus.halted, bus.prog_len);
        end
    endtask

    task automatic test_start_no_prog();
        do_reset();
        start16();
        n_cmp++;
        if ({bus.instr_valid, bus.busy, bus.halted} !== 3'b000) begin
            n_fail++;
            $display("FAIL start_empty: valid/busy/halted got %b/%b/%b want 0/0/0",
                     bus.instr_valid, bus.busy, bus.halted);
        end
        bus.start = 1'b1;
        bus.load_valid = 1'b1; bus.load_data = 8'h11; bus.load_last = 1'b0;
        tick();
        bus.start = 1'b0; bus.load_valid = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.instr_valid, bus.halted, bus.prog_len} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL start_vs_load: busy/valid/halted/len got %b/%b/%b/%h want 1/0/0/0",
                     bus.busy, bus.instr_valid, bus.halted, bus.prog_len);
        end
        tick();
        beat16(8'h22, 1'b1);
        n_cmp++;
        if ({bus.prog_len, bus.busy, bus.instr_valid} !== {5'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL load2: len/busy/valid got %h/%b/%b want 2/0/0",
                     bus.prog_len, bus.busy, bus.instr_valid);
        end
        bus.instr_ready = 1'b1;
        start16();
        n_cmp++;
        if ({bus.pc, bus.instruction} !== {4'd0, 8'h11}) begin
            n_fail++;
            $display("FAIL load2_i0: pc/instr got %h/%h want 0/11", bus.pc, bus.instruction);
        end
        tick();
        n_cmp++;
        if ({bus.instr_valid, bus.pc, bus.instruction} !== {1'b1, 4'd1, 8'h22}) begin
            n_fail++;
            $display("FAIL load2_i1: valid/pc/instr got %b/%h/%h want 1/1/22",
                     bus.instr_valid, bus.pc, bus.instruction);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        beat4(8'h01, 1'b0);
        beat4(8'h02, 1'b0);
        beat4(8'h03, 1'b0);
        n_cmp++;
        if ({bus4.busy, bus4.load_error} !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_midload: busy/err got %b/%b want 1/0", bus4.busy, bus4.load_error);
        end
        beat4(8'h04, 1'b0);
        n_cmp++;
        if ({bus4.prog_len, bus4.load_error, bus4.busy, bus4.halted} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_status: len/err/busy/halted got %h/%b/%b/%b want 4/1/0/0",
                     bus4.prog_len, bus4.load_error, bus4.busy, bus4.halted);
        end
        bus4.instr_ready = 1'b1;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({bus4.instr_valid, bus4.pc, bus4.instruction} !== {1'b1, 2'(k), 8'(k + 1)}) begin
                n_fail++;
                $display("FAIL ovf_run%0d: valid/pc/instr got %b/%h/%h want 1/%h/%h",
                         k, bus4.instr_valid, bus4.pc, bus4.instruction, 2'(k), 8'(k + 1));
            end
            tick();
        end
        n_cmp++;
        if ({bus4.instr_valid, bus4.halted, bus4.pc} !== {1'b0, 1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL ovf_halt: valid/halted/pc got %b/%b/%h want 0/1/3",
                     bus4.instr_valid, bus4.halted, bus4.pc);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        load_prog3();
        bus.instr_ready = 1'b1;
        start16();
        tick();
        n_cmp++;
        if ({bus.instr_valid, bus.pc} !== {1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL pre_reset: valid/pc got %b/%h want 1/1", bus.instr_valid, bus.pc);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.instr_valid, bus.pc, bus.prog_len, bus.busy, bus.halted} !== {1'b0, 4'd0, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: valid/pc/len/busy/halted got %b/%h/%h/%b/%b want 0/0/0/0/0",
                     bus.instr_valid, bus.pc, bus.prog_len, bus.busy, bus.halted);
        end
        tick();
        reset = 1'b0;
        start16();
        n_cmp++;
        if ({bus.instr_valid, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_after_reset: valid/busy got %b/%b want 0/0", bus.instr_valid, bus.busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.load_data = '0;
        bus4.load_data = '0;
        test_reset();
        test_load_run();
        test_stall();
        test_load_in_run();
        test_start_no_prog();
        test_overflow();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
